udp_tx_mc: RTL
==============

Name: udp_tx_mc

Overview:
- Parametrised multi-channel successor to the single-stream UDP transmit path.
- Arbitrates up to NUM_CH independent payload sources round-robin.
- Builds complete Ethernet II / IPv4 / UDP frames on GMII, one byte per clock: preamble, headers, IP checksum, payload, zero-padding, FCS, inter-frame gap.
- Sits between user data FIFOs and the GMII/RGMII adapter.
- Instantiates the existing crc32_d8 for the FCS.

Parameters:
- NUM_CH, 4, number of payload channels (1..8).
- BOARD_MAC, 48'h00_11_22_33_44_55, source MAC.
- BOARD_IP, {8'd192,8'd168,8'd1,8'd10}, source IP.
- SRC_PORT_BASE, 16'd1234, UDP source port of channel 0; channel k uses base+k.
- DES_PORT_BASE, 16'd1234, UDP destination port of channel 0; channel k uses base+k.
- MAX_PAYLOAD, 1472, payload byte limit; longer requests are truncated.
- IFG_CYC, 12, idle cycles after each frame.
- VLAN_ID, 12'd1, VLAN id used only when the optional feature is compiled in.

Ports:
- clk  in  1  GMII transmit clock; all logic is on this clock.
- rst_n  in  1  Asynchronous active-low reset.
- tx_start_en  in  NUM_CH  Per-channel one-cycle start pulse.
- tx_byte_num  in  NUM_CH*16  Per-channel payload length; channel k is bits [16k+15:16k].
- tx_data  in  8  Payload byte for the granted channel.
- des_mac  in  48  Destination MAC, sampled at frame start.
- des_ip  in  32  Destination IP, sampled at frame start.
- tx_req  out  1  Payload read request to the granted channel.
- tx_ch  out  3  Index of the granted channel; valid while busy.
- tx_done  out  1  One-cycle pulse after the last FCS byte.
- done_ch  out  3  Channel index for tx_done.
- busy  out  1  High from grant until the end of IFG.
- gmii_tx_en  out  1  GMII data valid.
- gmii_txd  out  8  GMII data.

Behaviour:
- Reset: all outputs are 0. Pending flags, IP identification counter and round-robin pointer clear.
- Reset asserted mid-frame drops gmii_tx_en immediately. No tx_done is generated.
- Start latching:
  - Each tx_start_en bit sets a sticky pending flag, including while busy and including for the channel currently transmitting.
  - The flag clears when that channel is granted.
- Arbitration:
  - In IDLE, the grant goes to the first pending channel searching upward from last_grant+1, wrapping at NUM_CH.
  - The channel's tx_byte_num, des_mac and des_ip are latched at grant.
  - A latched length of 0 sends 18 pad bytes. Lengths above MAX_PAYLOAD are clamped to MAX_PAYLOAD.
- State machine: IDLE -> CHECK_SUM (3 cycles) -> PREAMBLE -> ETH_HEAD -> IP_HEAD -> UDP_HEAD -> TX_DATA -> PAD -> CRC -> IFG -> IDLE.
  - PREAMBLE: 7x 0x55 then 0xD5.
  - ETH_HEAD: 14 bytes, type 0x0800.
  - IP_HEAD: 20 bytes, version/IHL 0x45, TOS 0, TTL 0x40, protocol 0x11, flags 0x4000.
  - UDP_HEAD: 8 bytes.
  - TX_DATA: L bytes.
  - PAD: max(0, 18-L) bytes of 0x00. PAD is skipped when L>=18.
  - CRC: 4 bytes.
  - IFG: IFG_CYC cycles with gmii_tx_en=0.
- Length and checksum fields:
  - IP total length = 28+L (unpadded). UDP length = 8+L. UDP checksum = 0.
  - IP identification increments by 1 per frame and wraps 0xFFFF->0.
  - IP header checksum: 32-bit sum of the ten header half-words, carries folded twice, then one's complement.
- Payload handshake:
  - tx_req is high for exactly L cycles. The first tx_req cycle is the last UDP_HEAD byte.
  - tx_data is sampled the cycle after each tx_req.
  - No tx_req is issued during PAD.
- CRC:
  - crc_clr pulses in IDLE.
  - crc_en is high from the first ETH_HEAD byte through the last PAD/data byte.
  - FCS bytes come from crc32_d8 as today: first byte from crc_next[31:24], remaining from crc_data.
- tx_done and done_ch assert in the cycle after the last FCS byte. busy stays high through IFG.
- Simultaneous starts on several channels are served in round-robin order, one frame each.

Optional Feature:
- Macro UDP_TX_VLAN_EN.
- Defined: a 4-byte 802.1Q tag is inserted after the source MAC: 0x8100, then PCP=0, DEI=0, VLAN_ID. Minimum pad payload stays 18; pad is computed against 46 bytes after the tag.
- Undefined: untagged frames; VLAN_ID is unused.

Decomposition:
- Package udp_pkg holds:
  - state encoding;
  - ETH_TYPE_IP, IP_PROTO_UDP, IP_TTL, PREAMBLE_LEN, ETH_HEAD_LEN, IP_HEAD_LEN, UDP_HEAD_LEN, MIN_PAYLOAD (18), TPID_VLAN.
- Sub-module: reuse crc32_d8 unchanged. The round-robin arbiter stays inline.

Test Plan:
- Channel 0 start, L=32, des_ip 192.168.1.102 -> 8+14+20+8+32+4 = 86 gmii_tx_en cycles; IP total length 0x003C; UDP length 0x0028; ports 1234/1234; FCS matches reference CRC; tx_done with done_ch=0.
- L=5 -> exactly 5 tx_req cycles and 13 0x00 pad bytes; IP total length 0x0021; frame is 64 bytes excluding preamble.
- Starts on channels 1, 2 and 3 in the same cycle with last_grant=2 -> frames in order 3, 1, 2, each separated by at least 12 idle cycles.
- Channel 0 re-pulses start during its own frame -> a second channel 0 frame follows after IFG, with IP identification +1.
- L=2000 -> truncated to 1472 tx_req cycles; IP total length 0x05DC.
- rst_n low at the 10th IP_HEAD byte -> gmii_tx_en drops asynchronously, no tx_done; a fresh start after release sends a full frame with identification 0.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared encodings and frame-layout constants for the multi-channel UDP transmitter.
package udp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK_SUM,
    ST_PREAMBLE,
    ST_ETH_HEAD,
    ST_IP_HEAD,
    ST_UDP_HEAD,
    ST_TX_DATA,
    ST_PAD,
    ST_CRC,
    ST_IFG
  } state_e;

  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [7:0]  IP_TTL       = 8'h40;
  localparam logic [15:0] TPID_VLAN    = 16'h8100;

  localparam int PREAMBLE_LEN = 8;
  localparam int ETH_HEAD_LEN = 14;
  localparam int IP_HEAD_LEN  = 20;
  localparam int UDP_HEAD_LEN = 8;
  localparam int MIN_PAYLOAD  = 18;
  localparam int VLAN_TAG_LEN = 4;
  localparam int CSUM_CYC     = 3;
  localparam int CRC_LEN      = 4;

  // Wire order is LSB first, the CRC register is kept MSB first.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bit_rev8[i] = b[7-i];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 (poly 0x04C11DB7, init all ones); bits enter LSB first.
module crc32_d8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        crc_en,
  input  logic        crc_clr,
  output logic [31:0] crc_data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  logic [31:0] c;

  // NOTE: every always_comb variable gets a default first so no latch is inferred.
  always_comb begin
    c = crc_data;
    for (int i = 0; i < 8; i++) c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
    crc_next = c;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       crc_data <= '1;
    else if (crc_clr) crc_data <= '1;
    else if (crc_en)  crc_data <= crc_next;
  end

endmodule

// File: rtl/udp_tx_mc.sv
// Round-robin multi-channel Ethernet II / IPv4 / UDP frame builder on GMII.
// Optional 802.1Q tagging is compiled in with `define UDP_TX_VLAN_EN.
module udp_tx_mc
  import udp_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter logic [47:0] BOARD_MAC     = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP      = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] SRC_PORT_BASE = 16'd1234,
  parameter logic [15:0] DES_PORT_BASE = 16'd1234,
  parameter int          MAX_PAYLOAD   = 1472,
  parameter int          IFG_CYC       = 12,
  parameter logic [11:0] VLAN_ID       = 12'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    tx_start_en,
  input  logic [NUM_CH*16-1:0] tx_byte_num,
  input  logic [7:0]           tx_data,
  input  logic [47:0]          des_mac,
  input  logic [31:0]          des_ip,
  output logic                 tx_req,
  output logic [2:0]           tx_ch,
  output logic                 tx_done,
  output logic [2:0]           done_ch,
  output logic                 busy,
  output logic                 gmii_tx_en,
  output logic [7:0]           gmii_txd
);

`ifdef UDP_TX_VLAN_EN
  localparam int ETH_LEN = ETH_HEAD_LEN + VLAN_TAG_LEN;
`else
  localparam int ETH_LEN = ETH_HEAD_LEN;
`endif

  state_e              state_q, state_d;
  logic [10:0]         cnt_q, cnt_d, len_q, len_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [2:0]          last_q, last_d, ch_q, ch_d, done_ch_q, done_ch_d;
  logic [47:0]         mac_q, mac_d;
  logic [31:0]         dip_q, dip_d, sum_q, sum_d;
  logic [15:0]         id_q, id_d, csum_q, csum_d;
  logic [7:0]          txd_q, txd_d;
  logic                en_q, en_d, crc_en_q, crc_en_d, done_q, done_d;
  logic [31:0]         crc_data, crc_next, fold;
  logic                gnt_ok;
  logic [2:0]          gnt_idx;
  int                  idx;
  logic [15:0]         raw_len, ip_tot, udp_len;
  logic [10:0]         pad_len;
  logic [ETH_LEN*8-1:0] eth_hdr, eth_sh;
  logic [159:0]        ip_hdr, ip_sh;
  logic [63:0]         udp_hdr, udp_sh;

`ifdef UDP_TX_VLAN_EN
  assign eth_hdr = {mac_q, BOARD_MAC, TPID_VLAN, 4'h0, VLAN_ID, ETH_TYPE_IP};
`else
  logic unused_vlan;
  assign unused_vlan = ^VLAN_ID;
  assign eth_hdr = {mac_q, BOARD_MAC, ETH_TYPE_IP};
`endif

  assign ip_tot  = 16'(IP_HEAD_LEN + UDP_HEAD_LEN) + {5'd0, len_q};
  assign udp_len = 16'(UDP_HEAD_LEN) + {5'd0, len_q};
  assign ip_hdr  = {8'h45, 8'h00, ip_tot, id_q, 16'h4000, IP_TTL, IP_PROTO_UDP, csum_q,
                    BOARD_IP, dip_q};
  assign udp_hdr = {SRC_PORT_BASE + {13'd0, ch_q}, DES_PORT_BASE + {13'd0, ch_q}, udp_len, 16'h0};
  assign pad_len = (len_q < 11'(MIN_PAYLOAD)) ? 11'(MIN_PAYLOAD) - len_q : 11'd0;
  assign eth_sh  = eth_hdr << {cnt_q, 3'b000};
  assign ip_sh   = ip_hdr << {cnt_q, 3'b000};
  assign udp_sh  = udp_hdr << {cnt_q, 3'b000};
  assign fold    = {16'h0, sum_q[31:16]} + {16'h0, sum_q[15:0]};

  // First pending channel above the last grant, wrapping.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = last_q;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (!gnt_ok && (((pend_q >> idx) & NUM_CH'(1)) != '0)) begin
        gnt_ok  = 1'b1;
        gnt_idx = 3'(idx);
      end
    end
    raw_len = 16'(tx_byte_num >> {gnt_idx, 4'b0000});
  end

  // The first payload request overlaps the last UDP header byte (one-cycle source latency).
  assign tx_req = ((state_q == ST_UDP_HEAD) && (cnt_q == 11'(UDP_HEAD_LEN - 1)) && (len_q != '0)) ||
                  ((state_q == ST_TX_DATA) && (cnt_q + 11'd1 < len_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 11'd1;
    pend_d    = pend_q | tx_start_en;
    last_d    = last_q;
    ch_d      = ch_q;
    len_d     = len_q;
    mac_d     = mac_q;
    dip_d     = dip_q;
    id_d      = id_q;
    sum_d     = sum_q;
    csum_d    = csum_q;
    txd_d     = 8'h00;
    en_d      = 1'b0;
    crc_en_d  = 1'b0;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (gnt_ok) begin
          ch_d    = gnt_idx;
          last_d  = gnt_idx;
          pend_d  = (pend_q & ~(NUM_CH'(1) << gnt_idx)) | tx_start_en;
          len_d   = (raw_len > 16'(MAX_PAYLOAD)) ? 11'(MAX_PAYLOAD) : raw_len[10:0];
          mac_d   = des_mac;
          dip_d   = des_ip;
          state_d = ST_CHECK_SUM;
        end
      end
      ST_CHECK_SUM: begin
        if (cnt_q == 11'd0) begin
          sum_d = 32'h4500 + {16'h0, ip_tot} + {16'h0, id_q} + 32'h4000 +
                  {16'h0, IP_TTL, IP_PROTO_UDP} + {16'h0, BOARD_IP[31:16]} +
                  {16'h0, BOARD_IP[15:0]} + {16'h0, dip_q[31:16]} + {16'h0, dip_q[15:0]};
        end else if (cnt_q == 11'd1) begin
          sum_d = fold;
        end else begin
          csum_d  = ~fold[15:0];
          cnt_d   = '0;
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        en_d  = 1'b1;
        txd_d = (cnt_q == 11'(PREAMBLE_LEN - 1)) ? 8'hD5 : 8'h55;
        if (cnt_q == 11'(PREAMBLE_LEN - 1)) begin cnt_d = '0; state_d = ST_ETH_HEAD; end
      end
      ST_ETH_HEAD: begin
        {en_d, crc_en_d} = 2'b11;
        txd_d = eth_sh[ETH_LEN*8-1 -: 8];
        if (cnt_q == 11'(ETH_LEN - 1)) begin cnt_d = '0; state_d = ST_IP_HEAD; end
      end
      ST_IP_HEAD: begin
        {en_d, crc_en_d} = 2'b11;
        txd_d = ip_sh[159 -: 8];
        if (cnt_q == 11'(IP_HEAD_LEN - 1)) begin cnt_d = '0; state_d = ST_UDP_HEAD; end
      end
      ST_UDP_HEAD: begin
        {en_d, crc_en_d} = 2'b11;
        txd_d = udp_sh[63 -: 8];
        if (cnt_q == 11'(UDP_HEAD_LEN - 1)) begin
          cnt_d   = '0;
          state_d = (len_q != '0) ? ST_TX_DATA : ST_PAD;
        end
      end
      ST_TX_DATA: begin
        {en_d, crc_en_d} = 2'b11;
        txd_d = tx_data;
        if (cnt_q == len_q - 11'd1) begin
          cnt_d   = '0;
          state_d = (pad_len != '0) ? ST_PAD : ST_CRC;
        end
      end
      ST_PAD: begin
        {en_d, crc_en_d} = 2'b11;
        if (cnt_q == pad_len - 11'd1) begin cnt_d = '0; state_d = ST_CRC; end
      end
      ST_CRC: begin
        // The last data/pad byte is still entering the CRC while FCS byte 0 is formed.
        en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_d = ~bit_rev8(crc_next[31:24]);
          2'd1:    txd_d = ~bit_rev8(crc_data[23:16]);
          2'd2:    txd_d = ~bit_rev8(crc_data[15:8]);
          default: txd_d = ~bit_rev8(crc_data[7:0]);
        endcase
        if (cnt_q == 11'(CRC_LEN - 1)) begin
          cnt_d   = '0;
          id_d    = id_q + 16'd1;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (cnt_q == 11'd0) begin done_d = 1'b1; done_ch_d = ch_q; end
        if (cnt_q == 11'(IFG_CYC - 1)) begin cnt_d = '0; state_d = ST_IDLE; end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      last_q    <= '0;
      ch_q      <= '0;
      len_q     <= '0;
      mac_q     <= '0;
      dip_q     <= '0;
      id_q      <= '0;
      sum_q     <= '0;
      csum_q    <= '0;
      txd_q     <= '0;
      en_q      <= 1'b0;
      crc_en_q  <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
      ch_q      <= ch_d;
      len_q     <= len_d;
      mac_q     <= mac_d;
      dip_q     <= dip_d;
      id_q      <= id_d;
      sum_q     <= sum_d;
      csum_q    <= csum_d;
      txd_q     <= txd_d;
      en_q      <= en_d;
      crc_en_q  <= crc_en_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
    end
  end

  crc32_d8 u_crc32_d8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (txd_q),
    .crc_en   (crc_en_q),
    .crc_clr  (state_q == ST_IDLE),
    .crc_data (crc_data),
    .crc_next (crc_next)
  );

  assign busy       = (state_q != ST_IDLE);
  assign tx_ch      = ch_q;
  assign tx_done    = done_q;
  assign done_ch    = done_ch_q;
  assign gmii_tx_en = en_q;
  assign gmii_txd   = txd_q;

endmodule
